// File: rtl/com_bus_rr_arbiter.sv
// Common-bus arbiter for the 4-core MESI subsystem: a round-robin processor channel
// and a round-robin snoop channel (memory lowest priority), both with registered grants.
module com_bus_rr_arbiter #(
  parameter int N_PROC   = 8,
  parameter int N_SNOOP  = 4,
  parameter int MAX_HOLD = 0,
  parameter int CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PROC-1:0]           Com_Bus_Req_proc,
  output logic [N_PROC-1:0]           Com_Bus_Gnt_proc,
  input  logic [N_SNOOP-1:0]          Com_Bus_Req_snoop,
  output logic [N_SNOOP-1:0]          Com_Bus_Gnt_snoop,
  input  logic                        Mem_snoop_req,
  output logic                        Mem_snoop_gnt,
  output logic [$clog2(N_PROC)-1:0]   Proc_owner,
  output logic                        Proc_busy,
  output logic                        Snoop_busy,
  output logic                        Hold_timeout
);

  localparam int PW  = $clog2(N_PROC);
  localparam int PW1 = PW + 1;
  localparam int SW  = $clog2(N_SNOOP);
  localparam int SW1 = SW + 1;

  localparam logic [PW:0]       P_NUM     = PW1'(N_PROC);
  localparam logic [PW-1:0]     P_LAST    = PW'(N_PROC - 1);
  localparam logic [SW:0]       S_NUM     = SW1'(N_SNOOP);
  localparam logic [SW-1:0]     S_LAST    = SW'(N_SNOOP - 1);
  localparam logic              HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } ch_state_t;

  // Returns {found, index} of the first request at or above ptr, wrapping to 0.
  function automatic logic [PW:0] rr_pick_proc(input logic [N_PROC-1:0] req,
                                               input logic [PW-1:0]     ptr);
    logic [PW:0] res;
    logic [PW:0] pos;
    res = '0;
    for (int k = N_PROC - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + PW1'(k);
      pos = (pos >= P_NUM) ? (pos - P_NUM) : pos;
      if (req[pos[PW-1:0]]) begin
        res = {1'b1, pos[PW-1:0]};
      end
    end
    return res;
  endfunction

  function automatic logic [SW:0] rr_pick_snoop(input logic [N_SNOOP-1:0] req,
                                                input logic [SW-1:0]      ptr);
    logic [SW:0] res;
    logic [SW:0] pos;
    res = '0;
    for (int k = N_SNOOP - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + SW1'(k);
      pos = (pos >= S_NUM) ? (pos - S_NUM) : pos;
      if (req[pos[SW-1:0]]) begin
        res = {1'b1, pos[SW-1:0]};
      end
    end
    return res;
  endfunction

  // ---------------- processor channel ----------------
  ch_state_t          p_state_r, p_state_next_s;
  logic [N_PROC-1:0]  p_gnt_r, p_gnt_next_s;
  logic [PW-1:0]      p_owner_r, p_owner_next_s;
  logic [PW-1:0]      p_ptr_r, p_ptr_next_s;
  logic [PW:0]        p_pick_s;
  logic [CNT_W-1:0]   p_cnt_r, p_cnt_next_s;
  logic               p_busy_r;
  logic               p_to_r, p_to_next_s;

  assign p_pick_s = rr_pick_proc(Com_Bus_Req_proc, p_ptr_r);

  // Processor channel next-state, grant, pointer and tenure logic.
  always_comb begin
    p_state_next_s = p_state_r;
    p_gnt_next_s   = p_gnt_r;
    p_owner_next_s = p_owner_r;
    p_ptr_next_s   = p_ptr_r;
    p_cnt_next_s   = p_cnt_r;
    case (p_state_r)
      ST_IDLE, ST_RELEASE: begin
        // RELEASE already is the dead cycle, so it arbitrates exactly like IDLE.
        if (p_pick_s[PW]) begin
          p_state_next_s = ST_GRANT;
          p_owner_next_s = p_pick_s[PW-1:0];
          p_gnt_next_s   = '0;
          p_gnt_next_s[p_pick_s[PW-1:0]] = 1'b1;
          p_ptr_next_s   = (p_pick_s[PW-1:0] == P_LAST) ? '0 : (p_pick_s[PW-1:0] + PW'(1));
          p_cnt_next_s   = '0;
        end else begin
          p_state_next_s = ST_IDLE;
          p_gnt_next_s   = '0;
        end
      end
      ST_GRANT: begin
        if (Com_Bus_Req_proc[p_owner_r]) begin
          p_cnt_next_s = (p_cnt_r == CNT_MAX) ? p_cnt_r : (p_cnt_r + CNT_W'(1));
        end else begin
          p_state_next_s = ST_RELEASE;
          p_gnt_next_s   = '0;
        end
      end
      default: begin
        p_state_next_s = ST_IDLE;
        p_gnt_next_s   = '0;
      end
    endcase
    // Fires on the cycle the count first reaches the limit, never again in the same tenure.
    p_to_next_s = HOLD_EN && (p_state_next_s == ST_GRANT) && (p_cnt_next_s == HOLD_LAST) &&
                  !((p_state_r == ST_GRANT) && (p_cnt_r == HOLD_LAST));
  end

  // Processor channel state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_state_r <= ST_IDLE;
      p_gnt_r   <= '0;
      p_owner_r <= '0;
      p_ptr_r   <= '0;
      p_cnt_r   <= '0;
      p_busy_r  <= 1'b0;
      p_to_r    <= 1'b0;
    end else begin
      p_state_r <= p_state_next_s;
      p_gnt_r   <= p_gnt_next_s;
      p_owner_r <= p_owner_next_s;
      p_ptr_r   <= p_ptr_next_s;
      p_cnt_r   <= p_cnt_next_s;
      p_busy_r  <= (p_state_next_s == ST_GRANT);
      p_to_r    <= p_to_next_s;
    end
  end

  // ---------------- snoop channel ----------------
  ch_state_t          s_state_r, s_state_next_s;
  logic [N_SNOOP-1:0] s_gnt_r, s_gnt_next_s;
  logic               s_mem_r, s_mem_next_s;
  logic [SW-1:0]      s_owner_r, s_owner_next_s;
  logic [SW-1:0]      s_ptr_r, s_ptr_next_s;
  logic [SW:0]        s_pick_s;
  logic               s_hold_s;
  logic               s_busy_r;

  assign s_pick_s = rr_pick_snoop(Com_Bus_Req_snoop, s_ptr_r);
  assign s_hold_s = s_mem_r ? Mem_snoop_req : Com_Bus_Req_snoop[s_owner_r];

  // Snoop channel next-state logic; memory only wins with no cache request and leaves ptr alone.
  always_comb begin
    s_state_next_s = s_state_r;
    s_gnt_next_s   = s_gnt_r;
    s_mem_next_s   = s_mem_r;
    s_owner_next_s = s_owner_r;
    s_ptr_next_s   = s_ptr_r;
    case (s_state_r)
      ST_IDLE, ST_RELEASE: begin
        if (s_pick_s[SW]) begin
          s_state_next_s = ST_GRANT;
          s_owner_next_s = s_pick_s[SW-1:0];
          s_gnt_next_s   = '0;
          s_gnt_next_s[s_pick_s[SW-1:0]] = 1'b1;
          s_mem_next_s   = 1'b0;
          s_ptr_next_s   = (s_pick_s[SW-1:0] == S_LAST) ? '0 : (s_pick_s[SW-1:0] + SW'(1));
        end else if (Mem_snoop_req) begin
          s_state_next_s = ST_GRANT;
          s_gnt_next_s   = '0;
          s_mem_next_s   = 1'b1;
        end else begin
          s_state_next_s = ST_IDLE;
          s_gnt_next_s   = '0;
          s_mem_next_s   = 1'b0;
        end
      end
      ST_GRANT: begin
        if (s_hold_s) begin
          s_state_next_s = ST_GRANT;
        end else begin
          s_state_next_s = ST_RELEASE;
          s_gnt_next_s   = '0;
          s_mem_next_s   = 1'b0;
        end
      end
      default: begin
        s_state_next_s = ST_IDLE;
        s_gnt_next_s   = '0;
        s_mem_next_s   = 1'b0;
      end
    endcase
  end

  // Snoop channel state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_state_r <= ST_IDLE;
      s_gnt_r   <= '0;
      s_mem_r   <= 1'b0;
      s_owner_r <= '0;
      s_ptr_r   <= '0;
      s_busy_r  <= 1'b0;
    end else begin
      s_state_r <= s_state_next_s;
      s_gnt_r   <= s_gnt_next_s;
      s_mem_r   <= s_mem_next_s;
      s_owner_r <= s_owner_next_s;
      s_ptr_r   <= s_ptr_next_s;
      s_busy_r  <= (s_state_next_s == ST_GRANT);
    end
  end

  assign Com_Bus_Gnt_proc  = p_gnt_r;
  assign Proc_owner        = p_owner_r;
  assign Proc_busy         = p_busy_r;
  assign Hold_timeout      = p_to_r;
  assign Com_Bus_Gnt_snoop = s_gnt_r;
  assign Mem_snoop_gnt     = s_mem_r;
  assign Snoop_busy        = s_busy_r;

endmodule

// File: tb/tb_com_bus_rr_arbiter.sv
// Self-checking bench for com_bus_rr_arbiter: table of hand-derived vectors fed through
// an expected-value queue, plus hand sequences for asynchronous reset corners.
module tb_com_bus_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_proc  = 8'h00;
  logic [7:0] gnt_proc;
  logic [3:0] req_snoop = 4'h0;
  logic [3:0] gnt_snoop;
  logic       mem_req   = 1'b0;
  logic       mem_gnt;
  logic [2:0] owner;
  logic       proc_busy;
  logic       snoop_busy;
  logic       hold_to;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rb;
    logic [7:0] rp;
    logic [3:0] rs;
    logic       rm;
    logic [7:0] gp;
    logic [3:0] gs;
    logic       gm;
    logic [2:0] own;
    logic       pb;
    logic       sb;
    logic       to;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  logic [7:0] one_hot_v;

  always #5 clk = ~clk;

  com_bus_rr_arbiter #(
    .N_PROC  (8),
    .N_SNOOP (4),
    .MAX_HOLD(4),
    .CNT_W   (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .Com_Bus_Req_proc (req_proc),
    .Com_Bus_Gnt_proc (gnt_proc),
    .Com_Bus_Req_snoop(req_snoop),
    .Com_Bus_Gnt_snoop(gnt_snoop),
    .Mem_snoop_req    (mem_req),
    .Mem_snoop_gnt    (mem_gnt),
    .Proc_owner       (owner),
    .Proc_busy        (proc_busy),
    .Snoop_busy       (snoop_busy),
    .Hold_timeout     (hold_to)
  );

  function automatic vec_t mk(input logic rb, input logic [7:0] rp, input logic [3:0] rs,
                              input logic rm, input logic [7:0] gp, input logic [3:0] gs,
                              input logic gm, input logic [2:0] own, input logic pb,
                              input logic sb, input logic to);
    vec_t v;
    v.rb = rb; v.rp = rp; v.rs = rs; v.rm = rm;
    v.gp = gp; v.gs = gs; v.gm = gm; v.own = own;
    v.pb = pb; v.sb = sb; v.to = to;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_proc = 8'h00; req_snoop = 4'h0; mem_req = 1'b0;
    #1;
    check("rst_gnt_proc", gnt_proc, 8'h00);
    check("rst_gnt_snoop", gnt_snoop, 4'h0);
    check("rst_mem_gnt", mem_gnt, 1'b0);
    check("rst_owner", owner, 3'd0);
    check("rst_proc_busy", proc_busy, 1'b0);
    check("rst_snoop_busy", snoop_busy, 1'b0);
    check("rst_timeout", hold_to, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one vector, queue its expectation, compare after the sampling edge.
  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    req_proc = v.rp; req_snoop = v.rs; mem_req = v.rm;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      e = sb_q.pop_front();
      check("gnt_proc", gnt_proc, e.gp);
      check("gnt_snoop", gnt_snoop, e.gs);
      check("mem_gnt", mem_gnt, e.gm);
      check("proc_busy", proc_busy, e.pb);
      check("snoop_busy", snoop_busy, e.sb);
      check("hold_timeout", hold_to, e.to);
      if (e.pb) check("proc_owner", owner, e.own);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // A: single requester, held five cycles; timeout on 4th grant cycle
    for (int k = 1; k <= 5; k++)
      vecs.push_back(mk(1'b0, 8'h01, 4'h0, 1'b0, 8'h01, 4'h0, 1'b0, 3'd0, 1'b1, 1'b0,
                        (k == 4) ? 1'b1 : 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    // B: all requesting after a fresh reset, each owner releases after 2 cycles
    for (int n = 0; n < 9; n++) begin
      one_hot_v = 8'h01 << (n % 8);
      vecs.push_back(mk((n == 0) ? 1'b1 : 1'b0, 8'hFF, 4'h0, 1'b0, one_hot_v, 4'h0, 1'b0,
                        3'(n % 8), 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 8'hFF, 4'h0, 1'b0, one_hot_v, 4'h0, 1'b0, 3'(n % 8),
                        1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 8'hFF & ~one_hot_v, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0,
                        1'b0, 1'b0, 1'b0));
    end
    vecs.push_back(mk(1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    // C: ptr to 5 via index 4, then 8'h81 -> 7 then 0
    vecs.push_back(mk(1'b0, 8'h10, 4'h0, 1'b0, 8'h10, 4'h0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h81, 4'h0, 1'b0, 8'h80, 4'h0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h01, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h81, 4'h0, 1'b0, 8'h01, 4'h0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    // D: cache snoop beats memory; concurrent proc grant; memory keeps snoop ptr
    vecs.push_back(mk(1'b0, 8'h02, 4'h4, 1'b1, 8'h02, 4'h4, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 8'h02, 4'h4, 1'b1, 8'h02, 4'h4, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 8'h02, 4'h0, 1'b1, 8'h02, 4'h0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h02, 4'h0, 1'b1, 8'h02, 4'h0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 4'h9, 1'b0, 8'h00, 4'h8, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 4'h1, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 4'h1, 1'b0, 8'h00, 4'h1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    // E: requester 2 holds 10 cycles, single timeout pulse
    for (int k = 1; k <= 10; k++)
      vecs.push_back(mk(1'b0, 8'h04, 4'h0, 1'b0, 8'h04, 4'h0, 1'b0, 3'd2, 1'b1, 1'b0,
                        (k == 4) ? 1'b1 : 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    // F: request withdrawn at the granting edge still gets one grant cycle
    vecs.push_back(mk(1'b0, 8'h08, 4'h0, 1'b0, 8'h08, 4'h0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rb) do_reset();
      apply(vecs[i]);
    end

    // Reset in the middle of active proc and snoop grants
    apply(mk(1'b0, 8'h10, 4'h1, 1'b0, 8'h10, 4'h1, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0));
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_gnt_proc", gnt_proc, 8'h00);
    check("midrst_gnt_snoop", gnt_snoop, 4'h0);
    check("midrst_proc_busy", proc_busy, 1'b0);
    check("midrst_snoop_busy", snoop_busy, 1'b0);
    req_proc = 8'h00; req_snoop = 4'h0; mem_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    apply(mk(1'b0, 8'h30, 4'h3, 1'b0, 8'h10, 4'h1, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0));
    apply(mk(1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
